// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencer and hazard unit for an N-stage in-order pipeline.
// Keeps per-stage shadows of valid/destination/load/halt, produces the
// register-stage advance and flush enables, the PC enable, the load-use
// bubble and the operand forwarding selects.
module pipe_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int REG_W          = 4,
    parameter int LOAD_STAGE     = 3,
    parameter int REDIRECT_STAGE = 2,
    parameter int FS_W           = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_rd1,
    input  logic [REG_W-1:0]      id_rd2,
    input  logic                  id_rd1_en,
    input  logic                  id_rd2_en,
    input  logic [REG_W-1:0]      id_wr_reg,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  id_is_hlt,
    input  logic                  redirect,
    input  logic                  mem_busy,
    output logic [NUM_STAGES-2:0] adv,
    output logic                  bubble_ex,
    output logic [NUM_STAGES-2:0] flush,
    output logic                  pc_en,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [FS_W-1:0]       fwd1,
    output logic [FS_W-1:0]       fwd2,
    output logic                  halted
);
    localparam int N = NUM_STAGES;
    // Registers 0..REDIRECT_STAGE-1 hold instructions younger than the redirect.
    localparam logic [N-2:0] REDIR_MASK = (N-1)'((1 << REDIRECT_STAGE) - 1);

    // Shadows of stages 2..N-1 (EX onward); ID comes straight from the inputs.
    logic [N-1:2]     sh_vld;
    logic [N-1:2]     sh_we;
    logic [N-1:2]     sh_ld;
    logic [N-1:2]     sh_hlt;
    logic [REG_W-1:0] sh_reg [2:N-1];

    logic            if_vld;
    logic            id_kill;
    logic            id_v;
    logic [FS_W-1:0] sel1;
    logic [FS_W-1:0] sel2;
    logic            late1;
    logic            late2;
    logic            stall;
    logic            drain;

    function automatic logic src_hit(input logic vld, input logic we,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src, input logic en);
        return vld & we & en & (dst == src) & (src != '0);
    endfunction

    // ID is real only if its register was not flushed after capture.
    assign id_v        = id_valid & ~id_kill;
    assign stage_valid = {sh_vld, id_v, if_vld};

    // Forwarding search: walk oldest to youngest so the youngest hit wins.
    always_comb begin
        sel1  = '0;
        sel2  = '0;
        late1 = 1'b0;
        late2 = 1'b0;
        for (int s = N - 1; s >= 2; s--) begin
            if (src_hit(sh_vld[s], sh_we[s], sh_reg[s], id_rd1, id_rd1_en)) begin
                sel1  = FS_W'(s - 1);
                late1 = sh_ld[s] & (s < LOAD_STAGE);
            end
            if (src_hit(sh_vld[s], sh_we[s], sh_reg[s], id_rd2, id_rd2_en)) begin
                sel2  = FS_W'(s - 1);
                late2 = sh_ld[s] & (s < LOAD_STAGE);
            end
        end
    end

    // A load whose data is not ready yet holds ID; any halt in ID or in flight drains.
    assign stall = id_v & (late1 | late2);
    assign drain = (id_v & id_is_hlt) | (|(sh_vld & sh_hlt));
    assign fwd1  = rst ? '0 : sel1;
    assign fwd2  = rst ? '0 : sel2;

    // Advance/flush/PC control, highest priority first.
    always_comb begin
        adv       = '1;
        flush     = '0;
        pc_en     = 1'b1;
        bubble_ex = 1'b0;
        if (rst) begin
            adv   = '0;
            flush = '1;
            pc_en = 1'b0;
        end else if (halted || mem_busy) begin
            adv   = '0;
            pc_en = 1'b0;
        end else if (redirect) begin
            flush = REDIR_MASK;
        end else if (stall) begin
            adv[1:0]  = 2'b00;
            pc_en     = 1'b0;
            bubble_ex = 1'b1;
        end else if (drain) begin
            adv[0]   = 1'b0;
            flush[0] = 1'b1;
            pc_en    = 1'b0;
        end
    end

    // Control shadows shift on advance; bubble or flush loads an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld <= '0;
            sh_we  <= '0;
            sh_ld  <= '0;
            sh_hlt <= '0;
        end else begin
            if (flush[1] || bubble_ex) begin
                sh_vld[2] <= 1'b0;
                sh_we[2]  <= 1'b0;
                sh_ld[2]  <= 1'b0;
                sh_hlt[2] <= 1'b0;
            end else if (adv[1]) begin
                sh_vld[2] <= id_v;
                sh_we[2]  <= id_wr_en;
                sh_ld[2]  <= id_is_load;
                sh_hlt[2] <= id_is_hlt;
            end
            for (int s = 3; s < N; s++) begin
                if (flush[s-1]) begin
                    sh_vld[s] <= 1'b0;
                    sh_we[s]  <= 1'b0;
                    sh_ld[s]  <= 1'b0;
                    sh_hlt[s] <= 1'b0;
                end else if (adv[s-1]) begin
                    sh_vld[s] <= sh_vld[s-1];
                    sh_we[s]  <= sh_we[s-1];
                    sh_ld[s]  <= sh_ld[s-1];
                    sh_hlt[s] <= sh_hlt[s-1];
                end
            end
        end
    end

    // Destination register shadows; rst forces flush so they clear too.
    always_ff @(posedge clk) begin
        if (flush[1] || bubble_ex) begin
            sh_reg[2] <= '0;
        end else if (adv[1]) begin
            sh_reg[2] <= id_wr_reg;
        end
        for (int s = 3; s < N; s++) begin
            if (flush[s-1]) begin
                sh_reg[s] <= '0;
            end else if (adv[s-1]) begin
                sh_reg[s] <= sh_reg[s-1];
            end
        end
    end

    // IF/ID occupancy tracking and the sticky halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted  <= 1'b0;
            if_vld  <= 1'b0;
            id_kill <= 1'b1;
        end else begin
            if (sh_vld[N-1] && sh_hlt[N-1]) begin
                halted <= 1'b1;
            end
            if (flush[0]) begin
                if_vld <= 1'b0;
            end else if (pc_en) begin
                if_vld <= 1'b1;
            end
            if (flush[0]) begin
                id_kill <= 1'b1;
            end else if (adv[0]) begin
                id_kill <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_pipe_ctrl;
    localparam int NS = 5;
    localparam int RW = 4;
    localparam int LS = 3;
    localparam int RS = 2;
    localparam int FW = $clog2(NS);
    localparam int VW = 2 * (NS - 1) + 2 + NS + 2 * FW + 1;

    logic clk;
    logic rst;
    logic id_valid;
    logic [RW-1:0] id_rd1, id_rd2, id_wr_reg;
    logic id_rd1_en, id_rd2_en, id_wr_en, id_is_load, id_is_hlt;
    logic redirect, mem_busy;

    logic [NS-2:0] adv, flush, adv4, flush4;
    logic bubble_ex, pc_en, halted, bubble_ex4, pc_en4, halted4;
    logic [NS-1:0] stage_valid, stage_valid4;
    logic [FW-1:0] fwd1, fwd2, fwd1_4, fwd2_4;

    logic [2*(NS-1)+1:0] ctl, ctl4;
    assign ctl  = {adv, flush, pc_en, bubble_ex};
    assign ctl4 = {adv4, flush4, pc_en4, bubble_ex4};

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.NUM_STAGES(NS), .REG_W(RW), .LOAD_STAGE(LS), .REDIRECT_STAGE(RS)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rd1_en(id_rd1_en), .id_rd2_en(id_rd2_en), .id_wr_reg(id_wr_reg),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_hlt(id_is_hlt),
        .redirect(redirect), .mem_busy(mem_busy), .adv(adv), .bubble_ex(bubble_ex),
        .flush(flush), .pc_en(pc_en), .stage_valid(stage_valid), .fwd1(fwd1),
        .fwd2(fwd2), .halted(halted));

    pipe_ctrl #(.NUM_STAGES(NS), .REG_W(RW), .LOAD_STAGE(4), .REDIRECT_STAGE(RS)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rd1_en(id_rd1_en), .id_rd2_en(id_rd2_en), .id_wr_reg(id_wr_reg),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_hlt(id_is_hlt),
        .redirect(redirect), .mem_busy(mem_busy), .adv(adv4), .bubble_ex(bubble_ex4),
        .flush(flush4), .pc_en(pc_en4), .stage_valid(stage_valid4), .fwd1(fwd1_4),
        .fwd2(fwd2_4), .halted(halted4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic v;
        logic we;
        logic ld;
        logic hl;
        logic [RW-1:0] rd;
    } instr_t;

    instr_t m_pipe [2:NS-1];
    logic m_if, m_kill, m_halted;
    logic [NS-2:0] e_adv, e_flush;
    logic e_pc, e_bub;
    logic [NS-1:0] e_sv;
    logic [FW-1:0] e_f1, e_f2;

    function automatic logic hit(instr_t p, logic [RW-1:0] src, logic en);
        return p.v && p.we && en && (src != 0) && (p.rd == src);
    endfunction

    task automatic model_reset;
        for (int s = 2; s < NS; s++) m_pipe[s] = '0;
        m_if = 1'b0;
        m_kill = 1'b1;
        m_halted = 1'b0;
    endtask

    task automatic model_eval;
        logic id_real, late, in_flight_halt;
        id_real = id_valid && !m_kill;
        e_f1 = '0;
        e_f2 = '0;
        late = 1'b0;
        for (int k = 1; k <= NS - 2; k++) begin
            if (e_f1 == 0 && hit(m_pipe[1+k], id_rd1, id_rd1_en)) begin
                e_f1 = FW'(k);
                if (m_pipe[1+k].ld && (1 + k) < LS) late = 1'b1;
            end
            if (e_f2 == 0 && hit(m_pipe[1+k], id_rd2, id_rd2_en)) begin
                e_f2 = FW'(k);
                if (m_pipe[1+k].ld && (1 + k) < LS) late = 1'b1;
            end
        end
        in_flight_halt = 1'b0;
        for (int s = 2; s < NS; s++) if (m_pipe[s].v && m_pipe[s].hl) in_flight_halt = 1'b1;
        e_adv = '1; e_flush = '0; e_pc = 1'b1; e_bub = 1'b0;
        if (rst) begin
            e_adv = '0; e_flush = '1; e_pc = 1'b0; e_f1 = '0; e_f2 = '0;
        end else if (m_halted || mem_busy) begin
            e_adv = '0; e_pc = 1'b0;
        end else if (redirect) begin
            for (int i = 0; i < RS; i++) e_flush[i] = 1'b1;
        end else if (id_real && late) begin
            e_adv[0] = 1'b0; e_adv[1] = 1'b0; e_pc = 1'b0; e_bub = 1'b1;
        end else if ((id_real && id_is_hlt) || in_flight_halt) begin
            e_adv[0] = 1'b0; e_flush[0] = 1'b1; e_pc = 1'b0;
        end
        e_sv[0] = m_if;
        e_sv[1] = id_real;
        for (int s = 2; s < NS; s++) e_sv[s] = m_pipe[s].v;
    endtask

    task automatic model_step;
        instr_t id_ins;
        id_ins = '{v: id_valid && !m_kill, we: id_wr_en, ld: id_is_load, hl: id_is_hlt, rd: id_wr_reg};
        if (rst) begin
            model_reset();
        end else begin
            if (m_pipe[NS-1].v && m_pipe[NS-1].hl) m_halted = 1'b1;
            for (int s = NS - 1; s >= 3; s--) begin
                if (e_flush[s-1]) m_pipe[s] = '0;
                else if (e_adv[s-1]) m_pipe[s] = m_pipe[s-1];
            end
            if (e_flush[1] || e_bub) m_pipe[2] = '0;
            else if (e_adv[1]) m_pipe[2] = id_ins;
            if (e_flush[0]) m_if = 1'b0;
            else if (e_pc) m_if = 1'b1;
            if (e_flush[0]) m_kill = 1'b1;
            else if (e_adv[0]) m_kill = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_in;
        id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_rd1_en = 0; id_rd2_en = 0;
        id_wr_reg = 0; id_wr_en = 0; id_is_load = 0; id_is_hlt = 0;
        redirect = 0; mem_busy = 0;
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] wr, input logic we,
                          input logic ld, input logic hl, input logic [RW-1:0] r1,
                          input logic e1, input logic [RW-1:0] r2, input logic e2);
        id_valid = v; id_wr_reg = wr; id_wr_en = we; id_is_load = ld; id_is_hlt = hl;
        id_rd1 = r1; id_rd1_en = e1; id_rd2 = r2; id_rd2_en = e2;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pipe;
        clear_in();
        rst = 1;
        next_cycle();
        rst = 0;
        next_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        clear_in();
        rst = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 10'b0000_1111_0_0) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 10'b0000_1111_0_0); end
        checks++;
        if ({fwd1, fwd2} !== 6'd0) begin errors++; $display("FAIL reset_fwd got=%b exp=0", {fwd1, fwd2}); end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({halted, stage_valid} !== 6'd0) begin errors++; $display("FAIL reset_state got=%b exp=0", {halted, stage_valid}); end
        rst = 0;
        id_valid = 1;
        #1;
        checks++;
        if (ctl !== 10'b1111_0000_1_0) begin errors++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 10'b1111_0000_1_0); end
        checks++;
        if (stage_valid !== 5'b00000) begin errors++; $display("FAIL reset_release_valid got=%b exp=00000", stage_valid); end
        next_cycle();
    endtask

    task automatic test_forward;
        rst_pipe();
        set_id(1, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd4, 1, 0, 0, 4'd3, 1, 4'd0, 0);
        @(negedge clk);
        checks++;
        if (fwd1 !== 3'd1) begin errors++; $display("FAIL fwd_ex got=%0d exp=1", fwd1); end
        checks++;
        if (ctl !== 10'b1111_0000_1_0) begin errors++; $display("FAIL fwd_ex_ctl got=%b exp=%b", ctl, 10'b1111_0000_1_0); end
        next_cycle();
        set_id(1, 4'd0, 0, 0, 0, 4'd3, 1, 4'd3, 0);
        @(negedge clk);
        checks++;
        if (fwd1 !== 3'd2) begin errors++; $display("FAIL fwd_mem got=%0d exp=2", fwd1); end
        checks++;
        if (fwd2 !== 3'd0) begin errors++; $display("FAIL fwd_disabled_src got=%0d exp=0", fwd2); end
        next_cycle();
    endtask

    task automatic test_r0_and_youngest;
        rst_pipe();
        set_id(1, 4'd0, 1, 1, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd7, 1, 0, 0, 4'd0, 1, 4'd0, 1);
        @(negedge clk);
        checks++;
        if ({fwd1, fwd2} !== 6'd0) begin errors++; $display("FAIL fwd_r0 got=%b exp=0", {fwd1, fwd2}); end
        checks++;
        if ({pc_en, bubble_ex} !== 2'b10) begin errors++; $display("FAIL r0_no_stall got=%b exp=10", {pc_en, bubble_ex}); end
        rst_pipe();
        set_id(1, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd0, 0, 0, 0, 4'd0, 0, 4'd3, 1);
        @(negedge clk);
        checks++;
        if (fwd2 !== 3'd1) begin errors++; $display("FAIL fwd_youngest got=%0d exp=1", fwd2); end
        next_cycle();
    endtask

    task automatic test_load_use;
        rst_pipe();
        set_id(1, 4'd5, 1, 1, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd6, 1, 0, 0, 4'd5, 1, 4'd0, 0);
        @(negedge clk);
        checks++;
        if ({ctl, fwd1} !== {10'b1100_0000_0_1, 3'd1}) begin errors++; $display("FAIL lu3_stall got=%b exp=%b", {ctl, fwd1}, {10'b1100_0000_0_1, 3'd1}); end
        checks++;
        if ({ctl4, fwd1_4} !== {10'b1100_0000_0_1, 3'd1}) begin errors++; $display("FAIL lu4_stall1 got=%b exp=%b", {ctl4, fwd1_4}, {10'b1100_0000_0_1, 3'd1}); end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ctl, fwd1} !== {10'b1111_0000_1_0, 3'd2}) begin errors++; $display("FAIL lu3_release got=%b exp=%b", {ctl, fwd1}, {10'b1111_0000_1_0, 3'd2}); end
        checks++;
        if ({ctl4, fwd1_4} !== {10'b1100_0000_0_1, 3'd2}) begin errors++; $display("FAIL lu4_stall2 got=%b exp=%b", {ctl4, fwd1_4}, {10'b1100_0000_0_1, 3'd2}); end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ctl4, fwd1_4} !== {10'b1111_0000_1_0, 3'd3}) begin errors++; $display("FAIL lu4_release got=%b exp=%b", {ctl4, fwd1_4}, {10'b1111_0000_1_0, 3'd3}); end
        next_cycle();
    endtask

    task automatic test_redirect_stall;
        rst_pipe();
        set_id(1, 4'd5, 1, 1, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd6, 1, 0, 0, 4'd5, 1, 4'd0, 0);
        redirect = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 10'b1111_0011_1_0) begin errors++; $display("FAIL redir_over_stall got=%b exp=%b", ctl, 10'b1111_0011_1_0); end
        next_cycle();
        redirect = 0;
        @(negedge clk);
        checks++;
        if (stage_valid !== 5'b01000) begin errors++; $display("FAIL redir_killed got=%b exp=01000", stage_valid); end
        next_cycle();
    endtask

    task automatic test_mem_busy;
        rst_pipe();
        set_id(1, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd6, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        next_cycle();
        set_id(1, 4'd0, 0, 0, 0, 4'd3, 1, 4'd6, 1);
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 10'b0000_0000_0_0) begin errors++; $display("FAIL busy_ctl cyc=%0d got=%b exp=0", i, ctl); end
            checks++;
            if ({fwd1, fwd2} !== {3'd2, 3'd1}) begin errors++; $display("FAIL busy_fwd cyc=%0d got=%b exp=%b", i, {fwd1, fwd2}, {3'd2, 3'd1}); end
            checks++;
            if (stage_valid !== 5'b01111) begin errors++; $display("FAIL busy_valid cyc=%0d got=%b exp=01111", i, stage_valid); end
            next_cycle();
        end
        mem_busy = 0;
        @(negedge clk);
        checks++;
        if ({ctl, fwd1, fwd2} !== {10'b1111_0000_1_0, 3'd2, 3'd1}) begin errors++; $display("FAIL busy_resume got=%b exp=%b", {ctl, fwd1, fwd2}, {10'b1111_0000_1_0, 3'd2, 3'd1}); end
        next_cycle();
        clear_in();
        @(negedge clk);
        checks++;
        if (stage_valid !== 5'b11101) begin errors++; $display("FAIL busy_no_loss got=%b exp=11101", stage_valid); end
        next_cycle();
    endtask

    task automatic test_halt;
        rst_pipe();
        set_id(1, 4'd0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
        @(negedge clk);
        checks++;
        if ({ctl, halted} !== {10'b1110_0001_0_0, 1'b0}) begin errors++; $display("FAIL halt_in_id got=%b exp=%b", {ctl, halted}, {10'b1110_0001_0_0, 1'b0}); end
        next_cycle();
        clear_in();
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({pc_en, halted} !== 2'b00) begin errors++; $display("FAIL halt_drain cyc=%0d got=%b exp=00", i, {pc_en, halted}); end
            next_cycle();
        end
        for (int i = 5; i <= 8; i++) begin
            redirect = 1'($urandom_range(0, 1));
            id_valid = 1;
            @(negedge clk);
            checks++;
            if ({adv, pc_en, halted} !== {4'b0000, 1'b0, 1'b1}) begin errors++; $display("FAIL halted_frozen cyc=%0d got=%b exp=000001", i, {adv, pc_en, halted}); end
            next_cycle();
        end
        clear_in();
        rst = 1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({halted, stage_valid} !== 6'd0) begin errors++; $display("FAIL halt_reset got=%b exp=0", {halted, stage_valid}); end
        rst = 0;
        next_cycle();
    endtask

    task automatic test_random;
        logic hold_redir;
        logic [VW-1:0] got, exp;
        clear_in();
        rst = 1;
        next_cycle();
        model_reset();
        hold_redir = 0;
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(0, 99) < 4);
            id_valid   = ($urandom_range(0, 99) < 80);
            id_rd1     = RW'($urandom_range(0, 5));
            id_rd2     = RW'($urandom_range(0, 5));
            id_rd1_en  = ($urandom_range(0, 99) < 70);
            id_rd2_en  = ($urandom_range(0, 99) < 50);
            id_wr_reg  = RW'($urandom_range(0, 5));
            id_wr_en   = ($urandom_range(0, 99) < 70);
            id_is_load = ($urandom_range(0, 99) < 30);
            id_is_hlt  = ($urandom_range(0, 99) < 2);
            redirect   = hold_redir || ($urandom_range(0, 99) < 10);
            mem_busy   = ($urandom_range(0, 99) < 12);
            hold_redir = redirect && mem_busy && !rst;
            @(negedge clk);
            model_eval();
            got = {adv, flush, pc_en, bubble_ex, stage_valid, fwd1, fwd2, halted};
            exp = {e_adv, e_flush, e_pc, e_bub, e_sv, e_f1, e_f2, m_halted};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, got, exp); end
            model_step();
            next_cycle();
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        clear_in();
        rst = 1;
        test_reset();
        test_forward();
        test_r0_and_youngest();
        test_load_use();
        test_redirect_stall();
        test_mem_busy();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline sequencer and hazard unit for the N-stage in-order core: stage 0 = IF, 1 = ID, N-1 = WB.
- Tracks per-stage valid/destination shadows and drives register-stage advance enables.
- Injects bubbles, flushes on redirect, drains on halt and freezes on memory wait.
- Generates operand forwarding selects.
- Generalises the fixed 5-stage, single-cycle load-use logic to arbitrary depth, load-ready stage and redirect stage.

Parameters:
NUM_STAGES, 5, pipeline depth (>=4)
REG_W, 4, register address width
LOAD_STAGE, 3, first stage where load data can be forwarded (2 < LOAD_STAGE < NUM_STAGES)
REDIRECT_STAGE, 2, stage whose redirect flushes all younger stages (1 <= REDIRECT_STAGE < NUM_STAGES-1)
FS_W, $clog2(NUM_STAGES), forward-select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rd1 / id_rd2  in  REG_W  ID source registers
id_rd1_en / id_rd2_en  in  1  source used
id_wr_reg  in  REG_W  ID destination
id_wr_en  in  1  ID writes a register
id_is_load  in  1  ID is a load
id_is_hlt  in  1  ID is halt
redirect  in  1  taken branch/jump resolved in REDIRECT_STAGE
mem_busy  in  1  data memory not ready this cycle
adv  out  NUM_STAGES-1  adv[i]=1: register between stage i and i+1 captures
bubble_ex  out  1  ID->EX register captures a no-op (valid=0)
flush  out  NUM_STAGES-1  flush[i]=1: register i->i+1 loads valid=0
pc_en  out  1  PC register update enable
stage_valid  out  NUM_STAGES  valid per stage (bit1 = id_valid & ~killed)
fwd1 / fwd2  out  FS_W  0 = register file; k = forward from stage 1+k
halted  out  1  halt reached WB; pipeline frozen

Behaviour:
- Reset (synchronous, clk edge with rst=1): all shadow valid/wr_en/is_load/is_hlt = 0; halted = 0; no stall or drain.
  - Outputs while rst high: adv = 0, flush = all 1s, pc_en = 0, fwd = 0, bubble_ex = 0.
  - Reset mid-stall or mid-drain discards all state.
- Shadows for stages 2..N-1 (valid, wr_en, wr_reg, is_load, is_hlt) shift when their adv bit is 1. A bubble or flush loads zeros.
- Forwarding, per source s:
  - Match at stage 1+k = valid & wr_en & wr_reg==id_rd_s & id_rd_s_en & id_rd_s != 0.
  - The youngest match (smallest k) wins. No match -> 0.
  - Combinational from registered shadows.
- Load-use stall: a winning match whose producer is_load and sits at stage < LOAD_STAGE raises stall.
  - stall = adv[0] = adv[1] = pc_en = 0; bubble_ex = 1; stages >=2 advance.
  - Stall re-evaluates each cycle and lasts exactly (LOAD_STAGE - producer stage) cycles. No single-cycle latch.
- Redirect (priority over stall and halt drain): flush[0..REDIRECT_STAGE-1] = 1 and pc_en = 1 (PC loads the target). The redirecting instruction itself advances.
- mem_busy: all adv = 0, pc_en = 0, no bubble. Forwarding outputs are held stable. mem_busy overrides redirect until it drops; redirect must stay asserted while frozen.
- Halt:
  - Halt valid in ID: pc_en = 0 and adv[0] = 0; IF contents are discarded (flush[0] = 1); the halt advances.
  - When halt valid in WB: halted = 1 (registered, sticky until rst). From then all adv = 0 and pc_en = 0.
  - A redirect from an older instruction still in flight flushes the halt if the halt is younger.
- Simultaneous stall + redirect: redirect wins, and the stalled ID instruction is flushed.
- Latency: all outputs except halted are combinational from inputs and shadows. halted rises the cycle after the halt reaches WB.

Test Plan:
1. ADD r3 in EX, ID reads r3 (rd1) -> fwd1=1, no stall; same producer one cycle later (MEM) -> fwd1=2.
2. LW r5 then dependent ADD, LOAD_STAGE=3 -> exactly 1 stall cycle (pc_en=0, bubble_ex=1), then fwd=2. With LOAD_STAGE=4 -> 2 stall cycles, then fwd=3.
3. Dependence on r0 with wr_en=1 in EX -> fwd1=0, no stall. Producers of r3 in both EX and MEM -> fwd selects EX (1).
4. Load-use stall active, redirect=1 same cycle -> flush[0..1]=1, pc_en=1, bubble_ex=0; next cycle stage_valid[1:0]=0.
5. mem_busy held 3 cycles mid-stream -> adv=0, pc_en=0, shadows and fwd unchanged for 3 cycles, then resume with no lost instruction.
6. HLT fetched with NUM_STAGES=5 -> pc_en=0 from ID onward, halted=1 after 4 cycles, stays 1. rst=1 -> halted=0, stage_valid=0 next edge.
